// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the PC and runs a single-outstanding fetch
// handshake to instruction memory. It holds one returned word while decode
// is stalled, applies EX-stage redirects, and drives the IF/ID register and
// the D/E flush lines.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic        StallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        misaligned_trap,
  output logic [31:0] misaligned_addr
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_DROP = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] hold_buf, hold_next;
  logic [31:0] target, deliver_word;
  logic        redirect, misaligned, deliver;

  // Redirect target selection and redirect/misalignment qualification.
  always_comb begin
    case (PCSrcE)
      2'b11:   target = ALUResultE & ~32'h0000_0001;
      default: target = PCTargetE;
    endcase
    redirect   = (PCSrcE != 2'b00) && (state != S_HALT);
    misaligned = redirect && target[1];
    pc_plus4   = pc + 32'd4;
  end

  // Next-state, next-PC and delivery decision for the fetch handshake.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    hold_next    = hold_buf;
    deliver      = 1'b0;
    deliver_word = hold_buf;
    if (misaligned) begin
      // The PC is frozen at the last good value; only reset leaves HALT.
      state_next = S_HALT;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc_next    = target;
            // An accepted request carries the stale address: drop its reply.
            state_next = imem_ready ? S_DROP : S_REQ;
          end else if (imem_ready) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_REQ;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_next    = target;
            state_next = imem_rvalid ? S_REQ : S_DROP;
          end else if (imem_rvalid && !StallF) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            pc_next      = pc_plus4;
            state_next   = S_REQ;
          end else if (imem_rvalid) begin
            hold_next  = imem_rdata;
            state_next = S_HOLD;
          end else begin
            state_next = S_WAIT;
          end
        end
        S_DROP: begin
          if (redirect) begin
            pc_next = target;
          end else begin
            pc_next = pc;
          end
          state_next = imem_rvalid ? S_REQ : S_DROP;
        end
        S_HOLD: begin
          if (redirect) begin
            pc_next    = target;
            state_next = S_REQ;
          end else if (!StallF) begin
            deliver      = 1'b1;
            deliver_word = hold_buf;
            pc_next      = pc_plus4;
            state_next   = S_REQ;
          end else begin
            state_next = S_HOLD;
          end
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_REQ;
      endcase
    end
  end

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      hold_buf <= 32'h0000_0000;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      hold_buf <= hold_next;
    end
  end

  // IF/ID pipeline register: flush beats delivery, delivery beats bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      validD   <= 1'b0;
    end else if (redirect) begin
      InstrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (deliver) begin
      InstrD   <= deliver_word;
      PCD      <= pc;
      PCPlus4D <= pc_plus4;
      validD   <= 1'b1;
    end else if (!StallF) begin
      validD <= 1'b0;
    end
  end

  // Misaligned-target trap pulse and sticky offending address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_trap <= 1'b0;
      misaligned_addr <= 32'h0000_0000;
    end else begin
      misaligned_trap <= misaligned;
      if (misaligned) begin
        misaligned_addr <= target;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign FlushD    = redirect;
  assign FlushE    = redirect;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios with
// literal expectations, then randomized traffic against a transaction-level
// model of the fetch unit and a small memory responder.
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        StallF, imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, validD, FlushD, FlushE, misaligned_trap;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D, misaligned_addr;

  fetch_redirect_unit dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .StallF(StallF), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .validD(validD), .FlushD(FlushD), .FlushE(FlushE),
    .misaligned_trap(misaligned_trap), .misaligned_addr(misaligned_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: transaction view of the fetch unit.
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4d, m_maddr, m_hword;
  logic        m_valid, m_trap, m_out, m_drop, m_held, m_halt, m_req;
  logic        accepted;

  // Memory responder state for the random phase.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          halt_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pcp4d = 32'h0;
    m_valid = 1'b0; m_trap = 1'b0; m_maddr = 32'h0; m_hword = 32'h0;
    m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt, w;
    logic        redir, mis, dlv;
    tgt   = (PCSrcE == 2'b11) ? (ALUResultE & ~32'd1) : PCTargetE;
    redir = (PCSrcE != 2'b00) && !m_halt;
    mis   = redir && tgt[1];
    dlv   = 1'b0;
    w     = 32'h0;
    if (mis) begin
      m_halt  = 1'b1;
      m_maddr = tgt;
    end else if (m_halt) begin
      dlv = 1'b0;
    end else if (m_held) begin
      if (redir) begin
        m_held = 1'b0; m_pc = tgt;
      end else if (!StallF) begin
        dlv = 1'b1; w = m_hword; m_held = 1'b0;
      end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out = 1'b0;
        if (m_drop || redir) m_drop = 1'b0;
        else if (!StallF) begin dlv = 1'b1; w = imem_rdata; end
        else begin m_held = 1'b1; m_hword = imem_rdata; end
      end else if (redir) begin
        m_drop = 1'b1;
      end
      if (redir) m_pc = tgt;
    end else begin
      if (imem_ready) begin m_out = 1'b1; m_drop = redir; end
      if (redir) m_pc = tgt;
    end
    if (redir) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (dlv) begin
      m_instr = w; m_pcd = m_pc; m_pcp4d = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else if (!StallF) begin
      m_valid = 1'b0;
    end
    m_trap = mis;
  endtask

  // One clock: compare every output with the model, advance the model, and
  // return one time unit after the next rising edge.
  task automatic cycle();
    logic redir;
    #2;
    if (reset) model_reset();
    m_req    = !m_halt && !m_out && !m_held;
    redir    = (PCSrcE != 2'b00) && !m_halt;
    accepted = !reset && m_req && imem_ready;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcp4d);
    chk("validD", {31'd0, validD}, {31'd0, m_valid});
    chk("FlushD", {31'd0, FlushD}, {31'd0, redir});
    chk("FlushE", {31'd0, FlushE}, {31'd0, redir});
    chk("misaligned_trap", {31'd0, misaligned_trap}, {31'd0, m_trap});
    chk("misaligned_addr", misaligned_addr, m_maddr);
    if (!reset) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                        input logic stall, input logic rdy, input logic rv, input logic [31:0] rd);
    PCSrcE = src; PCTargetE = tgt; ALUResultE = alu; StallF = stall;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
  endtask

  initial begin
    reset = 1'b1;
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", {31'd0, validD}, 32'd0);

    // Sequential fetch.
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    chk("seq_req_wait", {31'd0, imem_req}, 32'd0);
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0050_0093); cycle();
    chk("seq_instr", InstrD, 32'h0050_0093);
    chk("seq_pcd", PCD, 32'h0);
    chk("seq_pcp4", PCPlus4D, 32'h4);
    chk("seq_valid", {31'd0, validD}, 32'd1);
    chk("seq_addr4", imem_addr, 32'h4);

    // Taken branch while waiting.
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    set_in(2'd1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("br_flushd", {31'd0, FlushD}, 32'd1);
    chk("br_flushe", {31'd0, FlushE}, 32'd1);
    cycle();
    chk("br_valid0", {31'd0, validD}, 32'd0);
    chk("br_drop_req", {31'd0, imem_req}, 32'd0);
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111); cycle();
    chk("br_dropped", {31'd0, validD}, 32'd0);
    chk("br_addr", imem_addr, 32'h40);
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0033); cycle();
    chk("br_pcd", PCD, 32'h40);
    chk("br_instr", InstrD, 32'h0000_0033);

    // Stall while the response arrives.
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF); cycle();
    chk("st_req", {31'd0, imem_req}, 32'd0);
    chk("st_instr_hold", InstrD, 32'h0000_0033);
    set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0); cycle(); cycle();
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cycle();
    chk("st_instr", InstrD, 32'hDEAD_BEEF);
    chk("st_valid", {31'd0, validD}, 32'd1);
    chk("st_addr", imem_addr, 32'h48);

    // Redirect coincident with acceptance.
    set_in(2'd2, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    chk("co_req", {31'd0, imem_req}, 32'd0);
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2222_2222); cycle();
    chk("co_valid", {31'd0, validD}, 32'd0);
    chk("co_addr", imem_addr, 32'h80);

    // Wrap-around.
    set_in(2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cycle();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0010_0073); cycle();
    chk("wr_pcd", PCD, 32'hFFFF_FFFC);
    chk("wr_pcp4", PCPlus4D, 32'h0);
    chk("wr_next", imem_addr, 32'h0);

    // Misaligned JALR.
    set_in(2'd3, 32'h500, 32'h103, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mis_flush", {31'd0, FlushD}, 32'd1);
    cycle();
    chk("mis_trap", {31'd0, misaligned_trap}, 32'd1);
    chk("mis_addr", misaligned_addr, 32'h102);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_pc", imem_addr, 32'h0);
    set_in(2'd1, 32'h40, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5);
    #1;
    chk("halt_noflush", {31'd0, FlushD}, 32'd0);
    cycle();
    chk("halt_trap0", {31'd0, misaligned_trap}, 32'd0);
    chk("halt_req", {31'd0, imem_req}, 32'd0);

    // Reset mid-WAIT, then a stale response.
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1; cycle(); reset = 1'b0;
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); cycle();
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd1);
    chk("mr_pcd", PCD, 32'h0);
    chk("mr_maddr", misaligned_addr, 32'h0);
    cycle();
    reset = 1'b0;
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678); cycle();
    chk("stale_valid", {31'd0, validD}, 32'd0);
    chk("stale_instr", InstrD, NOP);
    chk("stale_req", {31'd0, imem_req}, 32'd1);

    // Randomized traffic.
    mem_pend = 1'b0; mem_cnt = 0; mem_data = 32'h0; halt_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      int r;
      reset = (halt_cnt >= 6) || ($urandom % 300 == 0);
      r = $urandom % 32;
      if (r == 0) tgt = 32'hFFFF_FFFC;
      else if (r == 1) tgt = $urandom | 32'h2;
      else tgt = $urandom & ~32'h3;
      PCTargetE  = tgt;
      ALUResultE = tgt | {31'd0, 1'($urandom % 2)};
      r = $urandom % 16;
      PCSrcE = (reset || r < 13) ? 2'd0 : 2'(1 + $urandom % 3);
      StallF = ($urandom % 3 == 0);
      imem_ready = !mem_pend && ($urandom % 4 != 0);
      if (mem_pend && mem_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_data;
      end else begin
        imem_rvalid = !mem_pend && ($urandom % 16 == 0);
        imem_rdata  = $urandom;
      end
      cycle();
      if (imem_rvalid && mem_pend) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (accepted) begin
        mem_pend = 1'b1; mem_cnt = $urandom % 3; mem_data = $urandom;
      end
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
